mac_sequencer: RTL and testbench
================================

Name: mac_sequencer

Overview:
- Control block that runs one unsigned dot product of VEC_LEN operand pairs through the 16-bit accumulator.
- Accepts operand pairs on a valid/ready stream and registers each product into a single pipeline stage.
- Drives the accumulator's clear/enable/data inputs and collects its final value and a sticky overflow flag.
- Presents the result on a valid/ready output; sits between the operand fetch logic and the accumulator instance.

Parameters:
- DATA_W, 8, operand width (unsigned).
- ACC_W, 16, product/accumulator width; must equal 2*DATA_W.
- LEN_W, 8, width of the vector-length field.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- start  in  1  begin job; sampled only in IDLE
- vec_len  in  LEN_W  number of operand pairs; latched on start
- abort  in  1  cancel active job
- in_a  in  DATA_W  operand A
- in_b  in  DATA_W  operand B
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer accepts pair
- acc_clear  out  1  to accumulator clear
- acc_enable  out  1  to accumulator enable
- acc_data  out  ACC_W  to accumulator data_in (registered product)
- acc_out  in  ACC_W  from accumulator
- acc_overflow  in  1  from accumulator (carry of last add, not sticky)
- res_data  out  ACC_W  final sum
- res_ovf  out  1  any add in job overflowed
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; remaining=0; prod_reg=0; prod_vld=0; sticky=0; drain_cnt=0. All outputs 0: in_ready, acc_clear, acc_enable, acc_data, res_data, res_ovf, res_valid, busy.
- Reset mid-job discards the job. The accumulator is reset by the same rst.
- Outputs are combinational from state/registers only:
  - acc_enable=prod_vld
  - acc_data=prod_reg
  - acc_clear=(state==CLR) or (abort pulse cycle, see below)
  - in_ready=(state==RUN)
  - res_valid=(state==HOLD)
- States and transitions:
  - IDLE: start=1 -> CLR; latch remaining=vec_len; clear sticky.
  - CLR (1 cycle): acc_clear=1. Next: remaining==0 -> DRAIN, else RUN. acc_overflow is not sampled in CLR.
  - RUN: accept when in_valid&in_ready. On accept: prod_reg<=in_a*in_b (full ACC_W, unsigned); prod_vld<=1; remaining--. Otherwise prod_vld<=0. An accept with remaining==1 -> DRAIN.
  - DRAIN (exactly 2 cycles, drain_cnt 0..1, in_ready=0): cycle 1 flushes prod_vld (the last enable); prod_vld<=0. At end of cycle 2: res_data<=acc_out; res_ovf<=sticky|acc_overflow -> HOLD.
  - HOLD: res_data/res_ovf stable; res_ready=1 -> IDLE at that edge. res_ready in other states is ignored.
- sticky<=sticky|acc_overflow every RUN and DRAIN cycle. Overflow of any add in the job sets res_ovf, even if later adds carry 0.
- Latency: last pair accepted in cycle c -> res_valid first high in cycle c+3. Minimum job (vec_len=N, in_valid held high) = 1 (CLR) + N + 2 + 1 cycles to HOLD.
- Sum wraps modulo 2^ACC_W (accumulator behaviour); the controller does not saturate.
- vec_len=0: CLR -> DRAIN -> HOLD with res_data=0, res_ovf=0.
- start while busy: ignored; vec_len not re-latched.
- abort in CLR/RUN/DRAIN: next state IDLE; acc_clear=1 in the abort cycle; prod_vld<=0; no HOLD, no result.
- abort in HOLD or IDLE: ignored.
- abort and accept in the same RUN cycle: abort wins; the pair is not consumed (in_ready is forced to 0 that cycle).
- in_valid gaps in RUN: prod_vld drops; no accumulator enable; remaining unchanged.

Test Plan:
- vec_len=3; pairs (2,3),(4,5),(6,7) back-to-back; res_ready=1 -> res_data=68, res_ovf=0; res_valid 3 cycles after last accept; busy high from CLR to HOLD exit.
- vec_len=3; pairs (255,255),(255,255),(1,1) -> second add carries, third does not; res_data=64515 (0xFC03), res_ovf=1 (sticky).
- vec_len=0 start -> acc_clear one cycle, no in_ready; res_data=0, res_ovf=0; a second start during HOLD is ignored.
- vec_len=4; in_valid toggled 1,0,0,1,1,0,1 with pairs (1,1),(2,2),(3,3),(4,4); res_ready low 5 cycles -> res_data=30, held stable until res_ready, then IDLE.
- vec_len=5; abort after 2 accepts -> IDLE, acc_clear pulse, no res_valid. Next job vec_len=1 (9,9) -> res_data=81, res_ovf=0.
- rst low mid-RUN with prod_vld=1 -> all outputs 0 immediately (async). After release, job vec_len=2 (10,10),(1,2) -> res_data=102.

Source files
------------

// File: rtl/mac_sequencer.sv
// Sequencer for one unsigned dot product through an external 16-bit accumulator.
// Operand pairs go through a single product register before reaching the accumulator.
module mac_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              acc_clear,
  output logic              acc_enable,
  output logic [ACC_W-1:0]  acc_data,
  input  logic [ACC_W-1:0]  acc_out,
  input  logic              acc_overflow,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t             state_r;
  logic [LEN_W-1:0]   remaining_r;
  logic [ACC_W-1:0]   prod_r;
  logic               prod_vld_r;
  logic               sticky_r;
  logic               drain_cnt_r;
  logic [ACC_W-1:0]   res_data_r;
  logic               res_ovf_r;

  logic               active_s;
  logic               abort_s;
  logic [ACC_W-1:0]   prod_s;

  assign active_s = (state_r == CLR) || (state_r == RUN) || (state_r == DRAIN);
  assign abort_s  = abort && active_s;
  assign prod_s   = ACC_W'(in_a) * ACC_W'(in_b);

  // Abort also gates in_ready so a pair offered in the abort cycle is never consumed.
  assign in_ready   = (state_r == RUN) && !abort;
  assign acc_clear  = (state_r == CLR) || abort_s;
  assign acc_enable = prod_vld_r;
  assign acc_data   = prod_r;
  assign res_data   = res_data_r;
  assign res_ovf    = res_ovf_r;
  assign res_valid  = (state_r == HOLD);
  assign busy       = (state_r != IDLE);

  // Job sequencing FSM with product pipeline, overflow tracking and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      remaining_r <= '0;
      prod_r      <= '0;
      prod_vld_r  <= 1'b0;
      sticky_r    <= 1'b0;
      drain_cnt_r <= 1'b0;
      res_data_r  <= '0;
      res_ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          prod_vld_r <= 1'b0;
          if (start) begin
            state_r     <= CLR;
            remaining_r <= vec_len;
            sticky_r    <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        CLR: begin
          prod_vld_r  <= 1'b0;
          drain_cnt_r <= 1'b0;
          if (abort) begin
            state_r <= IDLE;
          end else if (remaining_r == '0) begin
            state_r <= DRAIN;
          end else begin
            state_r <= RUN;
          end
        end
        RUN: begin
          sticky_r <= sticky_r | acc_overflow;
          if (abort) begin
            state_r    <= IDLE;
            prod_vld_r <= 1'b0;
          end else if (in_valid) begin
            prod_r      <= prod_s;
            prod_vld_r  <= 1'b1;
            remaining_r <= remaining_r - LEN_W'(1);
            drain_cnt_r <= 1'b0;
            if (remaining_r == LEN_W'(1)) begin
              state_r <= DRAIN;
            end else begin
              state_r <= RUN;
            end
          end else begin
            prod_vld_r <= 1'b0;
          end
        end
        DRAIN: begin
          sticky_r   <= sticky_r | acc_overflow;
          prod_vld_r <= 1'b0;
          if (abort) begin
            state_r <= IDLE;
          end else if (!drain_cnt_r) begin
            drain_cnt_r <= 1'b1;
          end else begin
            // Last add has landed one cycle ago; its carry is still on acc_overflow.
            res_data_r  <= acc_out;
            res_ovf_r   <= sticky_r | acc_overflow;
            drain_cnt_r <= 1'b0;
            state_r     <= HOLD;
          end
        end
        HOLD: begin
          prod_vld_r <= 1'b0;
          if (res_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r    <= IDLE;
          prod_vld_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural accumulator and a result scoreboard.
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  vec_len;
  logic        abort;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_valid;
  logic        in_ready;
  logic        acc_clear;
  logic        acc_enable;
  logic [15:0] acc_data;
  logic [15:0] acc_out;
  logic        acc_overflow;
  logic [15:0] res_data;
  logic        res_ovf;
  logic        res_valid;
  logic        res_ready;
  logic        busy;

  typedef struct packed {
    logic [15:0] data;
    logic        ovf;
  } res_t;

  res_t        exp_q[$];
  res_t        cur_exp;
  logic [15:0] model_sum;
  logic        model_ovf;
  int          n_checks = 0;
  int          n_fail   = 0;

  mac_sequencer #(.DATA_W(8), .ACC_W(16), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .abort(abort),
    .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
    .acc_clear(acc_clear), .acc_enable(acc_enable), .acc_data(acc_data),
    .acc_out(acc_out), .acc_overflow(acc_overflow),
    .res_data(res_data), .res_ovf(res_ovf), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Accumulator: clear wins over enable; overflow is the carry of the most recent add.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_out      <= 16'd0;
      acc_overflow <= 1'b0;
    end else if (acc_clear) begin
      acc_out      <= 16'd0;
      acc_overflow <= 1'b0;
    end else if (acc_enable) begin
      {acc_overflow, acc_out} <= {1'b0, acc_out} + {1'b0, acc_data};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_reset();
    model_sum = 16'd0;
    model_ovf = 1'b0;
  endtask

  task automatic model_add(input logic [7:0] a, input logic [7:0] b);
    logic [16:0] t;
    t = {1'b0, model_sum} + {1'b0, 16'(a) * 16'(b)};
    model_ovf = model_ovf | t[16];
    model_sum = t[15:0];
  endtask

  task automatic push_exp();
    res_t e;
    e.data = model_sum;
    e.ovf  = model_ovf;
    exp_q.push_back(e);
  endtask

  task automatic start_job(input logic [7:0] len);
    start   = 1'b1;
    vec_len = len;
    model_reset();
    tick();
    start = 1'b0;
    chk("clr_acc_clear", acc_clear, 1);
    chk("clr_in_ready", in_ready, 0);
    chk("clr_busy", busy, 1);
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
    int k;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    model_add(a, b);
    tick();
  endtask

  task automatic wait_result(input bit check_lat);
    int k;
    k = 0;
    while (!res_valid && k < 50) begin
      tick();
      k++;
    end
    chk("res_valid_seen", res_valid, 1);
    if (check_lat) chk("latency_after_accept", k + 1, 3);
    if (exp_q.size() == 0) begin
      chk("scoreboard_underflow", 1, 0);
    end else begin
      cur_exp = exp_q.pop_front();
      chk("res_data", res_data, cur_exp.data);
      chk("res_ovf", res_ovf, cur_exp.ovf);
      chk("hold_busy", busy, 1);
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("idle_res_valid", res_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_acc_clear"}, acc_clear, 0);
    chk({tag, "_acc_enable"}, acc_enable, 0);
    chk({tag, "_acc_data"}, acc_data, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_ovf"}, res_ovf, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [6:0] pat;
    logic [7:0] idx;

    rst = 1'b0; start = 1'b0; vec_len = 8'd0; abort = 1'b0;
    in_a = 8'd0; in_b = 8'd0; in_valid = 1'b0; res_ready = 1'b0;
    model_reset();
    #2;
    check_all_zero("reset");
    tick();
    rst = 1'b1;
    tick();

    // Job 1: back-to-back pairs with res_ready held high throughout.
    res_ready = 1'b1;
    start_job(8'd3);
    send_pair(8'd2, 8'd3);
    send_pair(8'd4, 8'd5);
    send_pair(8'd6, 8'd7);
    in_valid = 1'b0;
    push_exp();
    chk("drain_busy", busy, 1);
    chk("drain_in_ready", in_ready, 0);
    wait_result(1'b1);
    release_result();

    // Job 2: overflow on the second add must stay sticky.
    start_job(8'd3);
    send_pair(8'd255, 8'd255);
    send_pair(8'd255, 8'd255);
    send_pair(8'd1, 8'd1);
    in_valid = 1'b0;
    push_exp();
    wait_result(1'b1);
    release_result();

    // Job 3: zero-length vector, plus a start request while holding.
    start_job(8'd0);
    push_exp();
    tick();
    chk("len0_acc_clear_once", acc_clear, 0);
    chk("len0_in_ready", in_ready, 0);
    wait_result(1'b0);
    start = 1'b1;
    vec_len = 8'd5;
    tick();
    start = 1'b0;
    chk("hold_ignores_start", res_valid, 1);
    release_result();
    tick();
    chk("no_restart_busy", busy, 0);

    // Job 4: in_valid gaps and a delayed consumer.
    start_job(8'd4);
    in_valid = 1'b0;
    tick();
    pat = 7'b1011001;
    idx = 8'd1;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i];
      in_a = idx;
      in_b = idx;
      tick();
      chk("gap_acc_enable", acc_enable, pat[i]);
      if (pat[i]) begin
        chk("gap_acc_data", acc_data, 32'(idx) * 32'(idx));
        model_add(idx, idx);
        idx = idx + 8'd1;
      end
    end
    in_valid = 1'b0;
    push_exp();
    wait_result(1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, cur_exp.data);
    end
    release_result();

    // Job 5: abort after two accepts; the abort cycle refuses a pending pair.
    start_job(8'd5);
    send_pair(8'd3, 8'd4);
    send_pair(8'd5, 8'd6);
    abort = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_acc_clear", acc_clear, 1);
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_result", res_valid, 0);
    end
    abort = 1'b1;
    #1;
    chk("idle_abort_no_clear", acc_clear, 0);
    tick();
    abort = 1'b0;
    start_job(8'd1);
    send_pair(8'd9, 8'd9);
    in_valid = 1'b0;
    push_exp();
    wait_result(1'b1);
    release_result();

    // Job 6: asynchronous reset while a product is in flight.
    start_job(8'd4);
    send_pair(8'd7, 8'd7);
    chk("pre_reset_enable", acc_enable, 1);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick();
    tick();
    rst = 1'b1;
    tick();
    start_job(8'd2);
    send_pair(8'd10, 8'd10);
    send_pair(8'd1, 8'd2);
    in_valid = 1'b0;
    push_exp();
    wait_result(1'b1);
    release_result();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
